alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Holds dispatched integer ALU / branch-compare micro-ops until both source operands are available.
- Issues at most one ready op per cycle to the ALU, as operand values, the 5-bit op type and the ROB index.
- Sits between the decoder/dispatch unit and the ALU.
- Snoops two result-broadcast buses: the ALU's own result and the load/store buffer's result.

Parameters:
- RS_SIZE_BIT, 3: log2 of entry count (8 entries).
- ROB_SIZE_BIT, `ROB_SIZE_BIT from config.v: ROB index width.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-high reset
- rdy_in  in  1  global ready; low freezes all state
- flush  in  1  mispredict clear from ROB
- disp_valid  in  1  dispatch request
- disp_op  in  5  op type, passed to ALU unchanged
- disp_vj, disp_vk  in  32 each  operand values (valid when tag not pending)
- disp_qj_busy, disp_qk_busy  in  1 each  operand still pending
- disp_qj, disp_qk  in  ROB_SIZE_BIT each  producer ROB tag
- disp_rob_idx  in  ROB_SIZE_BIT  destination ROB index
- full  out  1  no free entry
- cdb0_valid, cdb0_rob_idx, cdb0_value  in  1/ROB_SIZE_BIT/32  ALU broadcast
- cdb1_valid, cdb1_rob_idx, cdb1_value  in  1/ROB_SIZE_BIT/32  LSB broadcast
- alu_valid  out  1  issue strobe to ALU
- alu_r1, alu_r2  out  32 each  operands
- alu_op  out  5  op type
- alu_rob_idx  out  ROB_SIZE_BIT  ROB index

Behaviour:
- Reset (async, rst_in=1):
  - all entry busy bits = 0
  - alu_valid = 0; alu_r1 = alu_r2 = 0; alu_op = 0; alu_rob_idx = 0
  - full = 0
- Entry fields: busy, op, vj, vk, qj_busy, qk_busy, qj, qk, rob_idx.
- full:
  - combinational AND of all busy bits.
  - Dispatch must not assert disp_valid while full=1; a dispatch while full is dropped.
- Dispatch:
  - On a clock edge with rdy_in=1, disp_valid=1, full=0, flush=0, write the lowest-index free entry.
  - Same-cycle bypass: if an operand is pending and its tag matches a valid cdb0/cdb1 tag that cycle, store the broadcast value and mark the operand ready.
- Wakeup:
  - Each edge, every busy entry whose pending qj/qk matches a valid cdb tag captures the value and clears its pending bit.
  - Both operands may wake in the same cycle, from the same or from different buses.
- Issue:
  - Candidate = busy && !qj_busy && !qk_busy, evaluated on registered state.
  - Lowest-index candidate wins.
  - At the edge: alu_* registers load its fields, alu_valid=1, entry busy cleared.
  - No candidate: alu_valid=0. Other alu_* outputs hold their last values.
- Latency:
  - Op dispatched with both operands ready at edge N: alu_valid high after edge N+1.
  - Op woken by a broadcast at edge N: issues after edge N+1 at the earliest.
  - Wakeup is never combinationally forwarded to issue.
- Simultaneous events:
  - Issue and dispatch on the same edge are both allowed.
  - The issued entry becomes free only after the edge; dispatch cannot reuse it that edge.
- flush=1 (with rdy_in=1), at the edge:
  - all busy bits cleared
  - alu_valid=0
  - any dispatch in that cycle is ignored
  - flush takes priority over issue and dispatch
- rdy_in=0:
  - no state or output register changes, including flush and dispatch effects.
- Reset mid-operation:
  - Reset is asynchronous: outputs reach reset values immediately, and all pending entries are lost.

Decomposition:
- Shared config/package: ROB_SIZE_BIT, RS_SIZE_BIT, and the 5-bit op-type encodings (ADD/SUB, logic, shifts, SLT/SLTU, BEQ..BGEU) shared with dispatch and ALU.
- Sub-module rs_priority_select: parameterised lowest-index-first finder, returning found + index.
  - Used twice: once for the free slot, once for the ready entry.

Test Plan:
- Dispatch op 5'b00000 with vj=5, vk=7, both ready, rob_idx=3 at edge 1 -> alu_valid=1 after edge 2 with r1=5, r2=7, alu_op=0, alu_rob_idx=3; alu_valid=0 after edge 3.
- Dispatch with qj_busy=1, qj=6, vk=1 -> no issue. At a later edge cdb1_valid=1, rob_idx=6, value=0x100 -> issue on the following edge with r1=0x100, r2=1.
- Dispatch with qj=2 pending in the same cycle as cdb0 rob_idx=2, value=9 -> entry stores 9 and issues next edge.
- Dispatch 8 ops with both operands pending -> full=1. A 9th disp_valid is dropped. Wake entry 4 -> it issues, then full=0.
- Entries 1 and 5 become ready on the same edge -> entry 1 issues first, entry 5 on the next edge.
- Fill 3 entries, pulse flush -> full=0, no issue ever occurs. With rdy_in=0 during a cdb broadcast -> the broadcast is not captured.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// Shared widths and ALU op-type encodings used by dispatch, the reservation station and the ALU.
package alu_reservation_station_pkg;

  localparam int RS_SIZE_BIT  = 3;
  localparam int ROB_SIZE_BIT = 4;
  localparam int DATA_W       = 32;
  localparam int OP_W         = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_SLL  = 5'd5,
    OP_SRL  = 5'd6,
    OP_SRA  = 5'd7,
    OP_SLT  = 5'd8,
    OP_SLTU = 5'd9,
    OP_BEQ  = 5'd10,
    OP_BNE  = 5'd11,
    OP_BLT  = 5'd12,
    OP_BGE  = 5'd13,
    OP_BLTU = 5'd14,
    OP_BGEU = 5'd15
  } alu_op_e;

endpackage

// File: rtl/alu_reservation_station_rs_priority_select.sv
// Lowest-index-first finder: reports whether any request bit is set and the index of the lowest one.
module rs_priority_select #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station for ALU/branch ops: wakes on two CDBs, issues one ready op per cycle,
// one cycle after operands are registered ready; upstream must hold dispatch while full is high.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int RS_SIZE_BIT  = alu_reservation_station_pkg::RS_SIZE_BIT,
  parameter int ROB_SIZE_BIT = alu_reservation_station_pkg::ROB_SIZE_BIT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush,
  input  logic                    disp_valid,
  input  logic [OP_W-1:0]         disp_op,
  input  logic [DATA_W-1:0]       disp_vj,
  input  logic [DATA_W-1:0]       disp_vk,
  input  logic                    disp_qj_busy,
  input  logic                    disp_qk_busy,
  input  logic [ROB_SIZE_BIT-1:0] disp_qj,
  input  logic [ROB_SIZE_BIT-1:0] disp_qk,
  input  logic [ROB_SIZE_BIT-1:0] disp_rob_idx,
  output logic                    full,
  input  logic                    cdb0_valid,
  input  logic [ROB_SIZE_BIT-1:0] cdb0_rob_idx,
  input  logic [DATA_W-1:0]       cdb0_value,
  input  logic                    cdb1_valid,
  input  logic [ROB_SIZE_BIT-1:0] cdb1_rob_idx,
  input  logic [DATA_W-1:0]       cdb1_value,
  output logic                    alu_valid,
  output logic [DATA_W-1:0]       alu_r1,
  output logic [DATA_W-1:0]       alu_r2,
  output logic [OP_W-1:0]         alu_op,
  output logic [ROB_SIZE_BIT-1:0] alu_rob_idx
);

  localparam int N = 1 << RS_SIZE_BIT;

  typedef struct packed {
    logic                    busy;
    logic [OP_W-1:0]         op;
    logic [DATA_W-1:0]       vj;
    logic [DATA_W-1:0]       vk;
    logic                    qj_busy;
    logic                    qk_busy;
    logic [ROB_SIZE_BIT-1:0] qj;
    logic [ROB_SIZE_BIT-1:0] qk;
    logic [ROB_SIZE_BIT-1:0] rob_idx;
  } entry_t;

  entry_t ent_q [N];
  entry_t ent_d [N];
  entry_t disp_ent;

  logic [N-1:0]             busy_vec;
  logic [N-1:0]             cand_vec;
  logic                     free_found;
  logic [RS_SIZE_BIT-1:0]   free_idx;
  logic                     iss_found;
  logic [RS_SIZE_BIT-1:0]   iss_idx;

  logic                     alu_valid_q;
  logic [DATA_W-1:0]        alu_r1_q;
  logic [DATA_W-1:0]        alu_r2_q;
  logic [OP_W-1:0]          alu_op_q;
  logic [ROB_SIZE_BIT-1:0]  alu_rob_idx_q;

  // Returns {still_pending, value} after snooping both broadcast buses.
  function automatic logic [DATA_W:0] snoop(input logic pend, input logic [ROB_SIZE_BIT-1:0] tag,
                                            input logic [DATA_W-1:0] val);
    if (pend && cdb0_valid && cdb0_rob_idx == tag) return {1'b0, cdb0_value};
    if (pend && cdb1_valid && cdb1_rob_idx == tag) return {1'b0, cdb1_value};
    return {pend, val};
  endfunction

  always_comb begin
    busy_vec = '0;
    cand_vec = '0;
    for (int i = 0; i < N; i++) begin
      busy_vec[i] = ent_q[i].busy;
      cand_vec[i] = ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy;
    end
  end

  assign full = &busy_vec;

  rs_priority_select #(.N(N), .IW(RS_SIZE_BIT)) u_free_sel (
    .req_i   (~busy_vec),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  rs_priority_select #(.N(N), .IW(RS_SIZE_BIT)) u_issue_sel (
    .req_i   (cand_vec),
    .found_o (iss_found),
    .idx_o   (iss_idx)
  );

  always_comb begin
    disp_ent         = '0;
    disp_ent.busy    = 1'b1;
    disp_ent.op      = disp_op;
    disp_ent.qj      = disp_qj;
    disp_ent.qk      = disp_qk;
    disp_ent.rob_idx = disp_rob_idx;
    {disp_ent.qj_busy, disp_ent.vj} = snoop(disp_qj_busy, disp_qj, disp_vj);
    {disp_ent.qk_busy, disp_ent.vk} = snoop(disp_qk_busy, disp_qk, disp_vk);
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ent_d[i] = ent_q[i];
      {ent_d[i].qj_busy, ent_d[i].vj} = snoop(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
      {ent_d[i].qk_busy, ent_d[i].vk} = snoop(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk);
      if (iss_found && iss_idx == RS_SIZE_BIT'(i)) ent_d[i].busy = 1'b0;
    end
    // Free slot comes from registered busy bits, so the entry issuing now is never reused this edge.
    if (disp_valid && !full && free_found) ent_d[free_idx] = disp_ent;
    if (flush) begin
      for (int i = 0; i < N; i++) ent_d[i].busy = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < N; i++) ent_q[i] <= '0;
      alu_valid_q   <= 1'b0;
      alu_r1_q      <= '0;
      alu_r2_q      <= '0;
      alu_op_q      <= '0;
      alu_rob_idx_q <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < N; i++) ent_q[i] <= ent_d[i];
      alu_valid_q <= iss_found && !flush;
      if (iss_found && !flush) begin
        alu_r1_q      <= ent_q[iss_idx].vj;
        alu_r2_q      <= ent_q[iss_idx].vk;
        alu_op_q      <= ent_q[iss_idx].op;
        alu_rob_idx_q <= ent_q[iss_idx].rob_idx;
      end
    end
  end

  assign alu_valid   = alu_valid_q;
  assign alu_r1      = alu_r1_q;
  assign alu_r2      = alu_r2_q;
  assign alu_op      = alu_op_q;
  assign alu_rob_idx = alu_rob_idx_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: hand-computed vectors checked with immediate assertions.
module tb_alu_reservation_station;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush = 1'b0;
  logic        disp_valid = 1'b0;
  logic [4:0]  disp_op = '0;
  logic [31:0] disp_vj = '0, disp_vk = '0;
  logic        disp_qj_busy = 1'b0, disp_qk_busy = 1'b0;
  logic [3:0]  disp_qj = '0, disp_qk = '0, disp_rob_idx = '0;
  logic        full;
  logic        cdb0_valid = 1'b0, cdb1_valid = 1'b0;
  logic [3:0]  cdb0_rob_idx = '0, cdb1_rob_idx = '0;
  logic [31:0] cdb0_value = '0, cdb1_value = '0;
  logic        alu_valid;
  logic [31:0] alu_r1, alu_r2;
  logic [4:0]  alu_op;
  logic [3:0]  alu_rob_idx;

  int checks = 0;
  int errors = 0;

  alu_reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_rob_idx(disp_rob_idx), .full(full),
    .cdb0_valid(cdb0_valid), .cdb0_rob_idx(cdb0_rob_idx), .cdb0_value(cdb0_value),
    .cdb1_valid(cdb1_valid), .cdb1_rob_idx(cdb1_rob_idx), .cdb1_value(cdb1_value),
    .alu_valid(alu_valid), .alu_r1(alu_r1), .alu_r2(alu_r2),
    .alu_op(alu_op), .alu_rob_idx(alu_rob_idx)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk,
                      input logic [3:0] rob);
    disp_valid = 1'b1; disp_op = op; disp_vj = vj; disp_vk = vk;
    disp_qj_busy = qjb; disp_qj = qj; disp_qk_busy = qkb; disp_qk = qk; disp_rob_idx = rob;
  endtask

  task automatic cdb(input logic v0, input logic [3:0] t0, input logic [31:0] d0,
                     input logic v1, input logic [3:0] t1, input logic [31:0] d1);
    cdb0_valid = v0; cdb0_rob_idx = t0; cdb0_value = d0;
    cdb1_valid = v1; cdb1_rob_idx = t1; cdb1_value = d1;
  endtask

  task automatic issue_chk(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [4:0] op, input logic [3:0] rob);
    chk({tag, "_valid"}, 32'(alu_valid), 32'd1);
    chk({tag, "_r1"}, alu_r1, r1);
    chk({tag, "_r2"}, alu_r2, r2);
    chk({tag, "_op"}, 32'(alu_op), 32'(op));
    chk({tag, "_rob"}, 32'(alu_rob_idx), 32'(rob));
  endtask

  initial begin
    #1 rst_in = 1'b1;
    #1;
    chk("rst_valid", 32'(alu_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_r1", alu_r1, 32'd0);
    chk("rst_r2", alu_r2, 32'd0);
    chk("rst_op", 32'(alu_op), 32'd0);
    chk("rst_rob", 32'(alu_rob_idx), 32'd0);
    tick(); tick();
    rst_in = 1'b0;

    // Both operands ready at dispatch.
    disp(5'd0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    tick(); disp_valid = 1'b0;
    chk("ready_no_early", 32'(alu_valid), 32'd0);
    tick(); issue_chk("ready_issue", 32'd5, 32'd7, 5'd0, 4'd3);
    tick(); chk("ready_drop", 32'(alu_valid), 32'd0);
    chk("ready_r1_hold", alu_r1, 32'd5);

    // Pending qj woken by cdb1.
    disp(5'd2, 32'd0, 32'd1, 1'b1, 4'd6, 1'b0, 4'd0, 4'd1);
    tick(); disp_valid = 1'b0;
    tick(); chk("pend_wait", 32'(alu_valid), 32'd0);
    cdb(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h100);
    tick(); cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    chk("wake_no_fwd", 32'(alu_valid), 32'd0);
    tick(); issue_chk("wake_issue", 32'h100, 32'd1, 5'd2, 4'd1);
    tick(); chk("wake_drop", 32'(alu_valid), 32'd0);

    // Same-cycle bypass from cdb0 at dispatch.
    disp(5'd8, 32'd0, 32'd3, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4);
    cdb(1'b1, 4'd2, 32'd9, 1'b0, 4'd0, 32'd0);
    tick(); disp_valid = 1'b0; cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick(); issue_chk("bypass_issue", 32'd9, 32'd3, 5'd8, 4'd4);
    tick();

    // Fill all 8 entries: entry i waits on tags i and i+8.
    for (int i = 0; i < 8; i++) begin
      disp(5'd1, 32'd0, 32'd0, 1'b1, 4'(i), 1'b1, 4'(i + 8), 4'(i));
      tick();
      if (i == 6) chk("full_at7", 32'(full), 32'd0);
    end
    chk("full_at8", 32'(full), 32'd1);
    disp(5'd3, 32'hA, 32'hB, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    tick(); disp_valid = 1'b0;
    chk("ninth_full", 32'(full), 32'd1);
    tick(); chk("ninth_dropped", 32'(alu_valid), 32'd0);
    cdb(1'b1, 4'd4, 32'h44, 1'b1, 4'd12, 32'hCC);
    tick(); cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    chk("e4_wake_full", 32'(full), 32'd1);
    tick(); issue_chk("e4_issue", 32'h44, 32'hCC, 5'd1, 4'd4);
    chk("e4_not_full", 32'(full), 32'd0);

    // Entries 1 and 5 ready on the same edge.
    cdb(1'b1, 4'd1, 32'h1, 1'b1, 4'd5, 32'h5);
    tick();
    cdb(1'b1, 4'd9, 32'h9, 1'b1, 4'd13, 32'hD);
    tick(); cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    chk("two_rdy_wait", 32'(alu_valid), 32'd0);
    tick(); issue_chk("e1_first", 32'h1, 32'h9, 5'd1, 4'd1);
    tick(); issue_chk("e5_second", 32'h5, 32'hD, 5'd1, 4'd5);
    tick(); chk("two_rdy_drop", 32'(alu_valid), 32'd0);

    // Flush beats a ready entry and a same-cycle dispatch.
    cdb(1'b1, 4'd0, 32'h70, 1'b1, 4'd8, 32'h78);
    tick(); cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    flush = 1'b1;
    disp(5'd0, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
    tick(); flush = 1'b0; disp_valid = 1'b0;
    chk("flush_valid", 32'(alu_valid), 32'd0);
    chk("flush_full", 32'(full), 32'd0);
    cdb(1'b1, 4'd2, 32'h2, 1'b1, 4'd10, 32'hA);
    tick(); cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    chk("flush_no_issue1", 32'(alu_valid), 32'd0);
    tick(); chk("flush_no_issue2", 32'(alu_valid), 32'd0);

    // Broadcast while rdy_in is low must not be captured.
    disp(5'd4, 32'd0, 32'd2, 1'b1, 4'd3, 1'b0, 4'd0, 4'd6);
    tick(); disp_valid = 1'b0;
    rdy_in = 1'b0; cdb(1'b1, 4'd3, 32'h33, 1'b0, 4'd0, 32'd0);
    tick(); rdy_in = 1'b1; cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick(); chk("frz_no_cap1", 32'(alu_valid), 32'd0);
    tick(); chk("frz_no_cap2", 32'(alu_valid), 32'd0);
    cdb(1'b1, 4'd3, 32'h77, 1'b0, 4'd0, 32'd0);
    tick(); cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick(); issue_chk("frz_late_issue", 32'h77, 32'd2, 5'd4, 4'd6);

    // rdy_in low delays issue and holds alu_valid.
    disp(5'd5, 32'hA, 32'hB, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    tick(); disp_valid = 1'b0;
    rdy_in = 1'b0;
    tick(); chk("frz_issue_hold", 32'(alu_valid), 32'd0);
    rdy_in = 1'b1;
    tick(); issue_chk("frz_issue", 32'hA, 32'hB, 5'd5, 4'd9);
    rdy_in = 1'b0;
    tick(); chk("frz_valid_hold", 32'(alu_valid), 32'd1);
    rdy_in = 1'b1;
    tick(); chk("unfrz_drop", 32'(alu_valid), 32'd0);

    // Asynchronous reset mid-operation loses the pending entry.
    disp(5'd6, 32'd0, 32'd0, 1'b1, 4'd14, 1'b0, 4'd0, 4'd2);
    tick();
    disp(5'd7, 32'd1, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
    tick(); disp_valid = 1'b0;
    tick(); issue_chk("pre_rst_issue", 32'd1, 32'd4, 5'd7, 4'd5);
    #2 rst_in = 1'b1;
    #1;
    chk("arst_valid", 32'(alu_valid), 32'd0);
    chk("arst_r1", alu_r1, 32'd0);
    chk("arst_rob", 32'(alu_rob_idx), 32'd0);
    tick(); rst_in = 1'b0;
    cdb(1'b1, 4'd14, 32'hEE, 1'b0, 4'd0, 32'd0);
    tick(); cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick(); chk("arst_lost1", 32'(alu_valid), 32'd0);
    tick(); chk("arst_lost2", 32'(alu_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
